csa_tree_pipe: RTL
==================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined multi-operand adder built from a carry-save 3:2 reduction tree with a final carry-propagate add.
- Successor to the fixed 16-term, 64-bit combinational CSA adder. Term count, width, signedness and pipeline depth are generic.
- Adds per-term subtraction, a widened overflow-free result, and a valid/ready handshake with backpressure.
- Feeds the multiplier partial-product path and the multi-operand address/accumulate paths in the datapath.

Parameters:
- WIDTH, 64, bit width of each input term.
- TERMS, 16, number of input terms (>=2).
- SIGNED, 1, 1 = terms sign-extended, 0 = zero-extended.
- LVL_PER_STG, 2, number of CSA levels between pipeline registers (>=1).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- in_valid  in  1  input term set valid.
- in_ready  out  1  block accepts the input set this cycle.
- in_terms  in  TERMS*WIDTH  packed terms; term k at [k*WIDTH +: WIDTH].
- in_neg  in  TERMS  bit k = 1 subtracts term k.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  OUT_W  result; OUT_W = WIDTH + clog2(TERMS) + 1.

Behaviour:
- Reset (clr low, asynchronous): all pipeline valid bits, out_valid and out_sum go to 0. in_ready is 1 once reset is released. Any data in flight mid-operation is discarded, with no partial output.
- Extension: each term is extended to OUT_W bits, sign-extended if SIGNED = 1, otherwise zero-extended.
- Negation: a negated term is the bitwise inversion of the extended term. One correction term, zero-extended popcount(in_neg), is appended. The tree therefore reduces N = TERMS+1 terms, and negation costs no extra carry chain.
- Reduction rule: each level groups terms in threes into 3:2 reducers (C = majority shifted left 1, S = xor). Leftover 1 or 2 terms pass through unchanged. Reduction continues until 2 terms remain.
  - L = number of levels, computed as an elaboration-time localparam.
  - C-shift overflow beyond OUT_W is dropped. This is exact modulo 2^OUT_W, and OUT_W guarantees no true overflow.
- Pipelining:
  - A register stage follows every LVL_PER_STG levels, plus one register after the final carry-propagate adder.
  - LATENCY = ceil(L/LVL_PER_STG) + 1 cycles, exported as a localparam.
  - Default: N=17 gives L=6 (17→12→8→6→4→3→2), so LATENCY = 4.
  - If L is a multiple of LVL_PER_STG, no empty stage is inserted.
- Handshake:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - Stall: stall = out_valid && !out_ready.
  - in_ready = !stall, a combinational function of registered out_valid and out_ready.
  - While stalled, every stage register and valid bit holds. out_sum and out_valid must stay stable until accepted.
  - Bubbles are not collapsed. This is a global-stall pipeline.
- Throughput: one result per cycle when out_ready is held high. Results emerge in input order.
- Simultaneous events: an input is accepted in the same cycle the output drains, provided out_ready = 1.
- Boundary cases:
  - in_neg = all ones with all-zero terms → result 0.
  - in_valid low → a bubble propagates, and out_valid is low at that slot.
- Signedness of out_sum: two's complement when SIGNED = 1, unsigned when SIGNED = 0.

Decomposition:
- Shared package csa_pkg holds:
  - function clog2;
  - function csa_levels(n), which iterates n → 2*floor(n/3) + n mod 3 until n = 2;
  - localparam helpers for OUT_W and LATENCY.
- One sub-module: csa_3_2_level. It is a purely combinational single reduction level, parametrised by input count and width, and instantiated by generate per level.
- The final carry-propagate add is a plain behavioural "+" at OUT_W.

Test Plan:
- Terms 1..16, in_neg=0, SIGNED=1, out_ready=1 → out_sum = 136, out_valid exactly 4 cycles after the accepting edge.
- All terms 0xFFFF_FFFF_FFFF_FFFF, SIGNED=1: with in_neg=0 → −16 (OUT_W-bit two's complement); with in_neg=0xFFFF → +16.
- All terms 0x7FFF_FFFF_FFFF_FFFF, SIGNED=1 → 0x7_FFFF_FFFF_FFFF_FFF0; same with all 0xFF..F and SIGNED=0 → 0xF_FFFF_FFFF_FFFF_FFF0 (no overflow at OUT_W=69).
- Back-to-back: 20 consecutive random sets, out_ready=1 → 20 results on consecutive cycles, matching a reference model in order.
- Backpressure: drop out_ready for 3 cycles while out_valid=1 → out_sum stable, in_ready=0, no loss or duplication after release.
- Pull clr low with 3 sets in flight → out_valid=0 immediately; after release, first new set returns correct sum at LATENCY with no stale outputs.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared elaboration-time helpers for the pipelined carry-save multi-operand adder.
// Everything here is evaluated at elaboration only and does not become logic.
package csa_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Operand count left after one 3:2 level: each triple becomes two, leftovers pass through.
   function automatic int level_step(input int n);
      return 2 * (n / 3) + n % 3;
   endfunction

   function automatic int csa_levels(input int n);
      int m;
      int l;
      m = n;
      l = 0;
      while (m > 2) begin
         m = level_step(m);
         l++;
      end
      return l;
   endfunction

   function automatic int terms_at_level(input int n, input int lvl);
      int m;
      m = n;
      for (int i = 0; i < lvl; i++) m = level_step(m);
      return m;
   endfunction

   function automatic int out_width(input int width, input int terms);
      return width + clog2(terms) + 1;
   endfunction

   // Tree stages (ceil of levels per stage) plus the register behind the final adder.
   function automatic int pipe_latency(input int terms, input int lvl_per_stg);
      return (csa_levels(terms + 1) + lvl_per_stg - 1) / lvl_per_stg + 1;
   endfunction

   // The last level always gets a register so the final adder has a full cycle to itself.
   function automatic bit reg_after_level(input int lvl, input int levels, input int lvl_per_stg);
      return ((lvl + 1) % lvl_per_stg == 0) || (lvl == levels - 1);
   endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Valid/ready term-set bus into the adder and result bus out of it.
// master = producer of terms and consumer of results; slave = the adder.
interface csa_tree_pipe_if #(
   parameter int WIDTH = 64,
   parameter int TERMS = 16,
   parameter int OUT_W = csa_pkg::out_width(WIDTH, TERMS)
);
   logic                   in_valid;
   logic                   in_ready;
   logic [TERMS*WIDTH-1:0] in_terms;
   logic [TERMS-1:0]       in_neg;
   logic                   out_valid;
   logic                   out_ready;
   logic [OUT_W-1:0]       out_sum;

   modport master (
      output in_valid, in_terms, in_neg, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_terms, in_neg, out_ready,
      output in_ready, out_valid, out_sum
   );
endinterface

// File: rtl/csa_3_2_level.sv
// One combinational carry-save level: every triple becomes sum and shifted majority,
// leftover one or two operands pass through unchanged.
module csa_3_2_level
   import csa_pkg::*;
#(
   parameter  int N_IN  = 3,
   parameter  int WIDTH = 8,
   localparam int N_OUT = level_step(N_IN)
) (
   input  logic [N_IN*WIDTH-1:0]  terms,
   output logic [N_OUT*WIDTH-1:0] sums
);
   localparam int N_GRP = N_IN / 3;
   localparam int N_REM = N_IN % 3;

   for (genvar g = 0; g < N_GRP; g++) begin : g_grp
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;

      assign a = terms[(3*g)*WIDTH   +: WIDTH];
      assign b = terms[(3*g+1)*WIDTH +: WIDTH];
      assign c = terms[(3*g+2)*WIDTH +: WIDTH];

      assign sums[(2*g)*WIDTH +: WIDTH]   = a ^ b ^ c;
      // Carry bit shifted past the MSB is dropped; the sum is exact modulo 2^WIDTH.
      assign sums[(2*g+1)*WIDTH +: WIDTH] = ((a & b) | (a & c) | (b & c)) << 1;
   end

   if (N_REM > 0) begin : g_pass
      assign sums[2*N_GRP*WIDTH +: N_REM*WIDTH] = terms[3*N_GRP*WIDTH +: N_REM*WIDTH];
   end
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand adder: extend/negate, carry-save tree, carry-propagate add.
// Global-stall valid/ready pipeline; every stage freezes while the result is not taken.
module csa_tree_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter int TERMS       = 16,
   parameter int SIGNED      = 1,
   parameter int LVL_PER_STG = 2
) (
   input logic              clk,
   input logic              clr,
   csa_tree_pipe_if.slave   bus
);
   localparam int N        = TERMS + 1;
   localparam int LEVELS   = csa_levels(N);
   localparam int OUT_W    = out_width(WIDTH, TERMS);
   localparam int LATENCY  = pipe_latency(TERMS, LVL_PER_STG);
   localparam int TREE_STG = LATENCY - 1;
   localparam int EXT_W    = OUT_W - WIDTH;

   logic                  stall;
   logic [TREE_STG-1:0]   vld;
   logic                  out_valid_q;
   logic [OUT_W-1:0]      out_sum_q;
   logic [OUT_W-1:0]      cpa_sum;
   logic [N*OUT_W-1:0]    lvl0;
   logic [2*OUT_W-1:0]    last;

   assign stall         = out_valid_q && !bus.out_ready;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;

   // Subtraction as ~x + 1: invert here, and the +1s are gathered into one extra operand.
   always_comb begin : p_extend
      logic [WIDTH-1:0] term;
      logic [OUT_W-1:0] ext;
      logic [OUT_W-1:0] corr;
      // NOTE: blocking assignments in combinational blocks so the running count
      // is read back within the same evaluation; defaults first avoid latches.
      term = '0;
      ext  = '0;
      corr = '0;
      lvl0 = '0;
      for (int k = 0; k < TERMS; k++) begin
         term = bus.in_terms[k*WIDTH +: WIDTH];
         ext  = (SIGNED != 0) ? {{EXT_W{term[WIDTH-1]}}, term} : {{EXT_W{1'b0}}, term};
         lvl0[k*OUT_W +: OUT_W] = bus.in_neg[k] ? ~ext : ext;
         corr = corr + OUT_W'(bus.in_neg[k]);
      end
      lvl0[TERMS*OUT_W +: OUT_W] = corr;
   end

   for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
      localparam int N_IN  = terms_at_level(N, i);
      localparam int N_OUT = terms_at_level(N, i + 1);

      logic [N_IN*OUT_W-1:0]  d;
      logic [N_OUT*OUT_W-1:0] s;
      logic [N_OUT*OUT_W-1:0] q;

      if (i == 0) begin : g_src
         assign d = lvl0;
      end else begin : g_src
         assign d = g_lvl[i-1].q;
      end

      csa_3_2_level #(
         .N_IN  (N_IN),
         .WIDTH (OUT_W)
      ) u_level (
         .terms (d),
         .sums  (s)
      );

      if (reg_after_level(i, LEVELS, LVL_PER_STG)) begin : g_reg
         // NOTE: wide datapath registers carry no reset; the valid bits alone
         // decide whether their contents mean anything.
         always_ff @(posedge clk) begin
            if (!stall) q <= s;
         end
      end else begin : g_wire
         assign q = s;
      end
   end

   assign last    = g_lvl[LEVELS-1].q;
   assign cpa_sum = last[OUT_W-1:0] + last[2*OUT_W-1:OUT_W];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         vld         <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
      end else if (!stall) begin
         vld[0] <= bus.in_valid;
         for (int k = 1; k < TREE_STG; k++) vld[k] <= vld[k-1];
         out_valid_q <= vld[TREE_STG-1];
         // Bubbles leave the last result in place rather than loading stale tree data.
         if (vld[TREE_STG-1]) out_sum_q <= cpa_sum;
      end
   end
endmodule
